pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the multi-cycle RV32EC core, replacing the fixed 32-bit PC register. It computes the next fetch address for sequential, branch, register-jump and immediate-jump modes, adds trap entry/return with a saved exception PC, and emits a registered redirect pulse so fetch can flush. An optional return-address stack checks procedure returns against the recorded call sites.

## Interface
Parameters:
- XLEN, 32, address/data width (≥16)
- RESET_VECTOR, 0, pc_out value after reset
- RAS_DEPTH, 4, return-address-stack entries (power of 2, ≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- compressed  in  1  current instruction is 16-bit (increment 2, else 4)
- pc_mode  in  2  0=INC, 1=BRCH, 2=JREG, 3=JIMM
- hold  in  1  multi-cycle stall; PC and stack frozen
- reg_direct  in  XLEN  rs1 value for JREG
- imm_offset  in  XLEN  sign-extended immediate
- flag  in  1  branch condition from ALU
- trap_req  in  1  take trap
- trap_vector  in  XLEN  trap handler address
- trap_return  in  1  return from trap (mret)
- is_call  in  1  instruction is a call (rd=x1/x5)
- is_ret  in  1  instruction is a return (JREG via x1/x5)
- pc_out  out  XLEN  current PC, registered
- link_out  out  XLEN  combinational link/AUIPC result
- epc_out  out  XLEN  saved exception PC, registered
- redirect  out  1  registered 1-cycle pulse after any non-sequential update
- ras_top  out  XLEN  top-of-stack prediction
- ras_valid  out  1  stack non-empty
- ras_mispredict  out  1  registered 1-cycle pulse on return-target mismatch

## Operation
- inc = compressed ? 2 : 4, zero-extended to XLEN; all adds modulo 2^XLEN (wrap, no flag).
- Target by mode: INC pc+inc; BRCH flag ? pc+imm : pc+inc; JREG (reg_direct+imm) with bit0 cleared; JIMM pc+imm. Bit0 of every loaded PC forced 0.
- link_out: pc+imm when pc_mode=INC (AUIPC path), else pc+inc.
- Priority per edge: trap_req > hold > trap_return > pc_mode.
- trap_req (honoured even when hold=1, aborts multi-cycle op): epc <= pc_out; pc <= trap_vector & ~1; redirect <= 1.
- trap_return (hold=0): pc <= epc; redirect <= 1; epc unchanged.
- Normal update (hold=0, no trap): pc <= target; redirect <= 1 for taken BRCH, JREG, JIMM; 0 for INC and not-taken BRCH.
- hold=1 without trap: all state held, redirect <= 0, ras_mispredict <= 0.
- Return-address stack (committed normal update only; untouched by trap/hold/trap_return):
  - is_call: push pc+inc; at RAS_DEPTH entries overwrite oldest, count saturates.
  - is_ret with ras_valid: compare target against ras_top; mismatch -> ras_mispredict <= 1; pop.
  - is_ret on empty stack: no pop, no mispredict.
  - is_call and is_ret together: pop then push (top replaced, count unchanged); compare uses old top.
- ras_top = most recent entry, 0 when empty.

## Timing
- Reset (rst_n low, asynchronous): pc_out=RESET_VECTOR, epc_out=0, redirect=0, ras_mispredict=0, stack empty (ras_valid=0, ras_top=0).
- Reset deassertion mid-hold: first edge behaves per current inputs.
- pc_out, epc_out, redirect, ras_mispredict, ras_valid update one edge after the qualifying inputs; link_out and ras_top combinational from current state/inputs.
- redirect and ras_mispredict are single-cycle pulses; back-to-back qualifying edges yield consecutive high cycles.

## Configuration
- PC_RAS_EN defined: return-address stack, ras_top, ras_valid, ras_mispredict implemented as above.
- PC_RAS_EN undefined: no stack storage; is_call/is_ret ignored; ras_top=0, ras_valid=0, ras_mispredict=0 constantly. All other behaviour identical.

## Test plan
- Reset with RESET_VECTOR=0x100, release, mode INC, compressed=0,1,0 -> pc_out 0x100,0x104,0x106,0x10A; redirect stays 0.
- pc=0x200, BRCH imm=0xFFFFFFF0 flag=1 -> pc 0x1F0, redirect pulse; flag=0 compressed=1 -> pc 0x1F2, no pulse.
- JREG reg_direct=0x1003 imm=4 -> pc 0x1006; pc=0xFFFFFFFC INC -> pc 0x00000000 (wrap).
- pc=0x300 hold=1 with trap_req=1 trap_vector=0x81 -> pc 0x80, epc 0x300; then trap_return -> pc 0x300, redirect each time.
- PC_RAS_EN, RAS_DEPTH=2: calls at 0x10,0x20,0x30 (inc 4) -> ras_top 0x34; return to 0x34 no mispredict; return to 0x40 vs top 0x24 -> ras_mispredict pulse; third return on empty -> no pulse.
- Mid-sequence rst_n low during hold -> pc_out immediately RESET_VECTOR, stack empty, pulses 0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// ============================================================================
// pc_sequencer_if : control/result bundle between core control and the PC sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            compressed;
    logic [1:0]      pc_mode;
    logic            hold;
    logic [XLEN-1:0] reg_direct;
    logic [XLEN-1:0] imm_offset;
    logic            flag;
    logic            trap_req;
    logic [XLEN-1:0] trap_vector;
    logic            trap_return;
    logic            is_call;
    logic            is_ret;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] link_out;
    logic [XLEN-1:0] epc_out;
    logic            redirect;
    logic [XLEN-1:0] ras_top;
    logic            ras_valid;
    logic            ras_mispredict;

    modport master (
        output compressed, pc_mode, hold, reg_direct, imm_offset, flag,
               trap_req, trap_vector, trap_return, is_call, is_ret,
        input  pc_out, link_out, epc_out, redirect, ras_top, ras_valid, ras_mispredict
    );

    modport slave (
        input  compressed, pc_mode, hold, reg_direct, imm_offset, flag,
               trap_req, trap_vector, trap_return, is_call, is_ret,
        output pc_out, link_out, epc_out, redirect, ras_top, ras_valid, ras_mispredict
    );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : next-PC selection, trap entry/return, redirect pulse and an
// optional return-address stack (enabled by defining PC_RAS_EN).
// Revision 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  wire            clk,
    input  wire            rst_n,
    pc_sequencer_if.slave  bus
);
    localparam logic [1:0] C_MODE_INC  = 2'd0;
    localparam logic [1:0] C_MODE_BRCH = 2'd1;
    localparam logic [1:0] C_MODE_JREG = 2'd2;
    localparam logic [1:0] C_MODE_JIMM = 2'd3;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            redirect_q, redirect_d;

    logic [XLEN-1:0] w_inc, w_pc_inc, w_pc_imm, w_jreg, w_target;
    logic            w_taken;
    logic            w_commit;

    // 4 = 3'b100, 2 = 3'b010
    assign w_inc    = {{(XLEN-3){1'b0}}, ~bus.compressed, bus.compressed, 1'b0};
    assign w_pc_inc = pc_q + w_inc;
    assign w_pc_imm = pc_q + bus.imm_offset;
    assign w_jreg   = bus.reg_direct + bus.imm_offset;

    always_comb begin
        w_target = w_pc_inc;
        w_taken  = 1'b0;
        case (bus.pc_mode)
            C_MODE_BRCH: begin
                if (bus.flag) begin
                    w_target = w_pc_imm;
                    w_taken  = 1'b1;
                end
            end
            C_MODE_JREG: begin
                w_target = w_jreg;
                w_taken  = 1'b1;
            end
            C_MODE_JIMM: begin
                w_target = w_pc_imm;
                w_taken  = 1'b1;
            end
            default: ;
        endcase
        w_target[0] = 1'b0;
    end

    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        redirect_d = 1'b0;
        w_commit   = 1'b0;
        if (bus.trap_req) begin
            epc_d      = pc_q;
            pc_d       = {bus.trap_vector[XLEN-1:1], 1'b0};
            redirect_d = 1'b1;
        end else if (bus.hold) begin
            pc_d = pc_q;
        end else if (bus.trap_return) begin
            pc_d       = epc_q;
            redirect_d = 1'b1;
        end else begin
            pc_d       = w_target;
            redirect_d = w_taken;
            w_commit   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            redirect_q <= redirect_d;
        end
    end

    assign bus.pc_out   = pc_q;
    assign bus.epc_out  = epc_q;
    assign bus.redirect = redirect_q;
    assign bus.link_out = (bus.pc_mode == C_MODE_INC) ? w_pc_imm : w_pc_inc;

`ifdef PC_RAS_EN
    localparam int               C_PTR_W  = $clog2(RAS_DEPTH);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE = 1;
    localparam logic [C_PTR_W:0]   C_CNT_ONE = 1;
    localparam logic [C_PTR_W:0]   C_CNT_FULL = RAS_DEPTH[C_PTR_W:0];

    logic [XLEN-1:0]    ras_mem_q [RAS_DEPTH];
    logic [C_PTR_W-1:0] ras_ptr_q, ras_ptr_d, w_pop_ptr;
    logic [C_PTR_W:0]   ras_cnt_q, ras_cnt_d, w_pop_cnt;
    logic               ras_mis_q, ras_mis_d;
    logic               w_ras_wr;
    logic [XLEN-1:0]    w_ras_top;

    assign w_ras_top = (ras_cnt_q != '0) ? ras_mem_q[ras_ptr_q] : '0;

    // Pop is applied first so a combined call+return replaces the top in place.
    always_comb begin
        w_pop_ptr = ras_ptr_q;
        w_pop_cnt = ras_cnt_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        ras_mis_d = 1'b0;
        w_ras_wr  = 1'b0;
        if (w_commit) begin
            if (bus.is_ret && (ras_cnt_q != '0)) begin
                ras_mis_d = (w_target != w_ras_top);
                w_pop_ptr = ras_ptr_q - C_PTR_ONE;
                w_pop_cnt = ras_cnt_q - C_CNT_ONE;
            end
            ras_ptr_d = w_pop_ptr;
            ras_cnt_d = w_pop_cnt;
            if (bus.is_call) begin
                ras_ptr_d = w_pop_ptr + C_PTR_ONE;
                ras_cnt_d = (w_pop_cnt == C_CNT_FULL) ? w_pop_cnt : (w_pop_cnt + C_CNT_ONE);
                w_ras_wr  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            ras_mis_q <= 1'b0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
            ras_mis_q <= ras_mis_d;
        end
    end

    // Entries beyond the count are never read, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (w_ras_wr) begin
            ras_mem_q[ras_ptr_d] <= w_pc_inc;
        end
    end

    assign bus.ras_top        = w_ras_top;
    assign bus.ras_valid      = (ras_cnt_q != '0);
    assign bus.ras_mispredict = ras_mis_q;
`else
    logic w_unused_ras;
    assign w_unused_ras       = bus.is_call ^ bus.is_ret ^ w_commit;
    assign bus.ras_top        = '0;
    assign bus.ras_valid      = 1'b0;
    assign bus.ras_mispredict = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer : directed + randomized check of pc_sequencer against a
// queue-based reference model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;
    localparam int          XLEN  = 32;
    localparam logic [31:0] RV    = 32'h100;
    localparam int          DEPTH = 2;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    pc_sequencer_if #(.XLEN(XLEN)) bus_if ();

    pc_sequencer #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (DEPTH)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [31:0] m_pc, m_epc;
    logic        m_red, m_mis;
    logic [31:0] m_ras[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_top();
        return (m_ras.size() > 0) ? m_ras[$] : 32'h0;
    endfunction

    task automatic m_reset();
        m_pc  = RV;
        m_epc = 32'h0;
        m_red = 1'b0;
        m_mis = 1'b0;
        m_ras.delete();
    endtask

    task automatic m_update();
        logic [31:0] inc, tgt;
        logic        taken;
        inc   = bus_if.compressed ? 32'd2 : 32'd4;
        m_mis = 1'b0;
        if (bus_if.trap_req) begin
            m_epc = m_pc;
            m_pc  = bus_if.trap_vector & ~32'h1;
            m_red = 1'b1;
        end else if (bus_if.hold) begin
            m_red = 1'b0;
        end else if (bus_if.trap_return) begin
            m_pc  = m_epc;
            m_red = 1'b1;
        end else begin
            unique case (bus_if.pc_mode)
                2'd0: begin tgt = m_pc + inc; taken = 1'b0; end
                2'd1: begin tgt = bus_if.flag ? m_pc + bus_if.imm_offset : m_pc + inc; taken = bus_if.flag; end
                2'd2: begin tgt = bus_if.reg_direct + bus_if.imm_offset; taken = 1'b1; end
                default: begin tgt = m_pc + bus_if.imm_offset; taken = 1'b1; end
            endcase
            tgt = tgt & ~32'h1;
            if (RAS_EN) begin
                if (bus_if.is_ret && m_ras.size() > 0) begin
                    m_mis = (tgt != m_ras[$]);
                    void'(m_ras.pop_back());
                end
                if (bus_if.is_call) begin
                    m_ras.push_back(m_pc + inc);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
            end
            m_pc  = tgt;
            m_red = taken;
        end
    endtask

    task automatic step();
        logic [31:0] inc, exp_link;
        #1;
        inc      = bus_if.compressed ? 32'd2 : 32'd4;
        exp_link = (bus_if.pc_mode == 2'd0) ? m_pc + bus_if.imm_offset : m_pc + inc;
        chk("link_out", bus_if.link_out, exp_link);
        chk("ras_top", bus_if.ras_top, m_top());
        @(posedge clk);
        m_update();
        #1;
        chk("pc_out", bus_if.pc_out, m_pc);
        chk("epc_out", bus_if.epc_out, m_epc);
        chk("redirect", {31'h0, bus_if.redirect}, {31'h0, m_red});
        chk("ras_valid", {31'h0, bus_if.ras_valid}, {31'h0, (m_ras.size() > 0)});
        chk("ras_mispredict", {31'h0, bus_if.ras_mispredict}, {31'h0, m_mis});
        @(negedge clk);
    endtask

    task automatic set_in(input logic [1:0] mode, input logic comp = 1'b0, input logic flg = 1'b0,
                          input logic [31:0] rd = 32'h0, input logic [31:0] imm = 32'h0,
                          input logic call = 1'b0, input logic ret = 1'b0);
        bus_if.pc_mode     = mode;
        bus_if.compressed  = comp;
        bus_if.flag        = flg;
        bus_if.reg_direct  = rd;
        bus_if.imm_offset  = imm;
        bus_if.is_call     = call;
        bus_if.is_ret      = ret;
        bus_if.hold        = 1'b0;
        bus_if.trap_req    = 1'b0;
        bus_if.trap_vector = 32'h0;
        bus_if.trap_return = 1'b0;
    endtask

    task automatic cyc(input logic [1:0] mode, input logic comp = 1'b0, input logic flg = 1'b0,
                       input logic [31:0] rd = 32'h0, input logic [31:0] imm = 32'h0,
                       input logic call = 1'b0, input logic ret = 1'b0);
        set_in(mode, comp, flg, rd, imm, call, ret);
        step();
    endtask

    initial begin
        logic [31:0] r;
        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b0;
        set_in(2'd0);
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_pc", bus_if.pc_out, 32'h100);
        chk("rst_epc", bus_if.epc_out, 32'h0);
        chk("rst_redirect", {31'h0, bus_if.redirect}, 32'h0);
        chk("rst_ras_valid", {31'h0, bus_if.ras_valid}, 32'h0);
        chk("rst_ras_top", bus_if.ras_top, 32'h0);
        rst_n = 1'b1;

        // sequential fetch
        cyc(2'd0, 1'b0); chk("inc4", bus_if.pc_out, 32'h104);
        cyc(2'd0, 1'b1); chk("inc2", bus_if.pc_out, 32'h106);
        cyc(2'd0, 1'b0); chk("inc4b", bus_if.pc_out, 32'h10A);
        chk("inc_no_redirect", {31'h0, bus_if.redirect}, 32'h0);

        // branches and jumps
        cyc(2'd3, 1'b0, 1'b0, 32'h0, 32'h200 - 32'h10A); chk("jimm", bus_if.pc_out, 32'h200);
        cyc(2'd1, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFF0);     chk("brch_taken", bus_if.pc_out, 32'h1F0);
        chk("brch_redirect", {31'h0, bus_if.redirect}, 32'h1);
        cyc(2'd1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFF0);     chk("brch_not", bus_if.pc_out, 32'h1F2);
        chk("brch_not_redirect", {31'h0, bus_if.redirect}, 32'h0);
        cyc(2'd2, 1'b0, 1'b0, 32'h1003, 32'h4);          chk("jreg", bus_if.pc_out, 32'h1006);
        cyc(2'd3, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC - 32'h1006);
        cyc(2'd0, 1'b0);                                 chk("wrap", bus_if.pc_out, 32'h0);

        // trap entry during hold, then return
        cyc(2'd3, 1'b0, 1'b0, 32'h0, 32'h300);
        set_in(2'd0);
        bus_if.hold = 1'b1; bus_if.trap_req = 1'b1; bus_if.trap_vector = 32'h81;
        step();
        chk("trap_pc", bus_if.pc_out, 32'h80);
        chk("trap_epc", bus_if.epc_out, 32'h300);
        set_in(2'd0);
        bus_if.trap_return = 1'b1;
        step();
        chk("mret_pc", bus_if.pc_out, 32'h300);
        chk("mret_redirect", {31'h0, bus_if.redirect}, 32'h1);

        // return-address stack, depth 2
        cyc(2'd3, 1'b0, 1'b0, 32'h0, 32'h10 - 32'h300);
        cyc(2'd3, 1'b0, 1'b0, 32'h0, 32'h10, 1'b1);
        cyc(2'd3, 1'b0, 1'b0, 32'h0, 32'h10, 1'b1);
        cyc(2'd3, 1'b0, 1'b0, 32'h0, 32'h10, 1'b1);
`ifdef PC_RAS_EN
        chk("ras_top_after_calls", bus_if.ras_top, 32'h34);
`endif
        cyc(2'd2, 1'b0, 1'b0, 32'h34, 32'h0, 1'b0, 1'b1);
`ifdef PC_RAS_EN
        chk("ret_match_mis", {31'h0, bus_if.ras_mispredict}, 32'h0);
        chk("ras_top_after_pop", bus_if.ras_top, 32'h24);
`endif
        cyc(2'd2, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1);
`ifdef PC_RAS_EN
        chk("ret_mismatch", {31'h0, bus_if.ras_mispredict}, 32'h1);
`endif
        cyc(2'd2, 1'b0, 1'b0, 32'h50, 32'h0, 1'b0, 1'b1);
        chk("ret_empty_mis", {31'h0, bus_if.ras_mispredict}, 32'h0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            r = $urandom;
            set_in(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom,
                   {{20{r[11]}}, r[11:0]}, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            if (bus_if.is_ret && $urandom_range(0, 1) == 1) begin
                bus_if.pc_mode    = 2'd2;
                bus_if.reg_direct = m_top();
                bus_if.imm_offset = 32'h0;
            end
            bus_if.hold        = ($urandom_range(0, 4) == 0);
            bus_if.trap_req    = ($urandom_range(0, 19) == 0);
            bus_if.trap_vector = $urandom;
            bus_if.trap_return = ($urandom_range(0, 15) == 0);
            step();
        end

        // asynchronous reset in the middle of a hold
        set_in(2'd3, 1'b0, 1'b0, 32'h0, 32'h40, 1'b1);
        step();
        set_in(2'd1, 1'b0, 1'b1, 32'h0, 32'h20, 1'b1);
        bus_if.hold = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        chk("async_rst_pc", bus_if.pc_out, RV);
        chk("async_rst_epc", bus_if.epc_out, 32'h0);
        chk("async_rst_redirect", {31'h0, bus_if.redirect}, 32'h0);
        chk("async_rst_mis", {31'h0, bus_if.ras_mispredict}, 32'h0);
        chk("async_rst_valid", {31'h0, bus_if.ras_valid}, 32'h0);
        chk("async_rst_top", bus_if.ras_top, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("hold_after_rst", bus_if.pc_out, RV);
        cyc(2'd0, 1'b0);
        cyc(2'd3, 1'b0, 1'b0, 32'h0, 32'h8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

`default_nettype wire
